// File: rtl/pc_gen_unit.sv
// Program-counter generator for the IF stage: picks the next fetch address
// and holds redirects that arrive while fetch cannot advance.
module pc_gen_unit #(
    parameter int              ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter int              INST_BYTES   = 4,
    parameter bit              ALIGN_CHECK  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              jump_flag_i,
    input  logic [ADDR_W-1:0] jump_target_addr_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_addr_i,
    input  logic              if_ready_i,
    output logic [ADDR_W-1:0] pc,
    output logic              pc_valid_o,
    output logic              redirect_pending_o,
    output logic              misalign_o
);

    localparam logic [ADDR_W-1:0] INC = ADDR_W'(INST_BYTES);

    typedef enum logic {BOOT, RUN} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              adv;
    logic [ADDR_W-1:0] tgt;

    assign adv = !stall && if_ready_i;
    assign tgt = jump_flag_i ? jump_target_addr_i : branch_target_addr_i;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        if (state_q == BOOT) begin
            state_d = RUN;
        end
        if (flush) begin
            pc_d   = new_pc;
            pend_d = 1'b0;
        end else if (jump_flag_i || branch_flag_i) begin
            if (adv) begin
                pc_d   = tgt;
                pend_d = 1'b0;
            end else begin
                pend_d      = 1'b1;
                pend_addr_d = tgt;
            end
        end else if (adv && pend_q) begin
            pc_d   = pend_addr_q;
            pend_d = 1'b0;
        end else if (adv && state_q == RUN) begin
            // The first cycle out of reset fetches RESET_VECTOR itself.
            pc_d = pc_q + INC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= BOOT;
            pc_q        <= RESET_VECTOR;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    assign pc                 = pc_q;
    assign pc_valid_o         = (state_q == RUN);
    assign redirect_pending_o = pend_q;

    generate
        if (ALIGN_CHECK && INST_BYTES > 1) begin : g_align
            localparam int OFF_W = $clog2(INST_BYTES);
            assign misalign_o = |pc_q[OFF_W-1:0];
        end else begin : g_no_align
            assign misalign_o = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_pc_gen_unit.sv
// Scenario bench for pc_gen_unit: each task queues expected PC state per
// cycle and compares it against both DUT instances after the clock edge.
module tb_pc_gen_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] new_pc = '0;
    logic        jump_flag_i = 1'b0;
    logic [31:0] jump_target_addr_i = '0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_addr_i = '0;
    logic        if_ready_i = 1'b1;

    logic [31:0] pc;
    logic        pc_valid_o;
    logic        redirect_pending_o;
    logic        misalign_o;
    logic [31:0] pc_b;
    logic        pc_valid_b;
    logic        pend_b;
    logic        misalign_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        logic        jf;
        logic        bf;
        logic        rdy;
        logic [31:0] npc;
        logic [31:0] jt;
        logic [31:0] bt;
        logic [31:0] epc;
        logic        ev;
        logic        ep;
        logic        em;
    } stim_t;

    // Expected observation: pc, valid, pending, misalign, plus the
    // ALIGN_CHECK=0 instance's pc and misalign.
    logic [68:0] sb[$];

    always #5 clk = ~clk;

    pc_gen_unit #(
        .ADDR_W(32), .RESET_VECTOR(32'hBFC0_0000),
        .INST_BYTES(4), .ALIGN_CHECK(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .new_pc(new_pc),
        .jump_flag_i(jump_flag_i),
        .jump_target_addr_i(jump_target_addr_i),
        .branch_flag_i(branch_flag_i),
        .branch_target_addr_i(branch_target_addr_i),
        .if_ready_i(if_ready_i),
        .pc(pc), .pc_valid_o(pc_valid_o),
        .redirect_pending_o(redirect_pending_o),
        .misalign_o(misalign_o)
    );

    pc_gen_unit #(
        .ADDR_W(32), .RESET_VECTOR(32'hBFC0_0000),
        .INST_BYTES(4), .ALIGN_CHECK(1'b0)
    ) dut_na (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .new_pc(new_pc),
        .jump_flag_i(jump_flag_i),
        .jump_target_addr_i(jump_target_addr_i),
        .branch_flag_i(branch_flag_i),
        .branch_target_addr_i(branch_target_addr_i),
        .if_ready_i(if_ready_i),
        .pc(pc_b), .pc_valid_o(pc_valid_b),
        .redirect_pending_o(pend_b),
        .misalign_o(misalign_b)
    );

    task automatic apply(input stim_t s);
        rst                  = s.rst;
        stall                = s.stall;
        flush                = s.flush;
        jump_flag_i          = s.jf;
        branch_flag_i        = s.bf;
        if_ready_i           = s.rdy;
        new_pc               = s.npc;
        jump_target_addr_i   = s.jt;
        branch_target_addr_i = s.bt;
        sb.push_back({s.epc, s.ev, s.ep, s.em, s.epc, 1'b0});
    endtask

    task automatic test_reset();
        stim_t t[$];
        logic [68:0] e, got;
        t.push_back('{1,0,0,0,0,1,0,0,0, 32'hBFC0_0000,0,0,0});
        t.push_back('{0,0,0,0,0,1,0,0,0, 32'hBFC0_0000,1,0,0});
        t.push_back('{0,0,0,0,0,1,0,0,0, 32'hBFC0_0004,1,0,0});
        t.push_back('{0,0,0,0,0,1,0,0,0, 32'hBFC0_0008,1,0,0});
        t.push_back('{0,0,0,0,0,0,0,0,0, 32'hBFC0_0008,1,0,0});
        foreach (t[i]) begin
            apply(t[i]);
            @(posedge clk); #1;
            e   = sb.pop_front();
            got = {pc, pc_valid_o, redirect_pending_o, misalign_o,
                   pc_b, misalign_b};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset[%0d] got=%h exp=%h", i, got, e);
            end
        end
    endtask

    task automatic test_wrap();
        stim_t t[$];
        logic [68:0] e, got;
        t.push_back('{0,1,1,0,0,0,32'hFFFF_FFFC,0,0, 32'hFFFF_FFFC,1,0,0});
        t.push_back('{0,0,0,0,0,1,0,0,0, 32'h0000_0000,1,0,0});
        t.push_back('{0,0,0,0,0,1,0,0,0, 32'h0000_0004,1,0,0});
        foreach (t[i]) begin
            apply(t[i]);
            @(posedge clk); #1;
            e   = sb.pop_front();
            got = {pc, pc_valid_o, redirect_pending_o, misalign_o,
                   pc_b, misalign_b};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL wrap[%0d] got=%h exp=%h", i, got, e);
            end
        end
    endtask

    task automatic test_held_redirect();
        stim_t t[$];
        logic [68:0] e, got;
        t.push_back('{0,1,0,0,1,1,0,0,32'h0000_1000, 32'h0000_0004,1,1,0});
        t.push_back('{0,1,0,0,0,1,0,0,0, 32'h0000_0004,1,1,0});
        t.push_back('{0,0,0,0,0,1,0,0,0, 32'h0000_1000,1,0,0});
        t.push_back('{0,0,0,0,0,1,0,0,0, 32'h0000_1004,1,0,0});
        // Newer redirect overwrites older; if_ready_i low also holds.
        t.push_back('{0,0,0,1,0,0,0,32'h0000_2000,0, 32'h0000_1004,1,1,0});
        t.push_back('{0,1,0,0,1,1,0,0,32'h0000_3000, 32'h0000_1004,1,1,0});
        t.push_back('{0,0,0,0,0,0,0,0,0, 32'h0000_1004,1,1,0});
        t.push_back('{0,0,0,0,0,1,0,0,0, 32'h0000_3000,1,0,0});
        foreach (t[i]) begin
            apply(t[i]);
            @(posedge clk); #1;
            e   = sb.pop_front();
            got = {pc, pc_valid_o, redirect_pending_o, misalign_o,
                   pc_b, misalign_b};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL held[%0d] got=%h exp=%h", i, got, e);
            end
        end
    endtask

    task automatic test_priority();
        stim_t t[$];
        logic [68:0] e, got;
        t.push_back('{0,1,0,0,1,1,0,0,32'h0000_6000, 32'h0000_3000,1,1,0});
        t.push_back('{0,1,1,1,1,1,32'h8000_0180,32'h0000_4000,32'h0000_5000,
                      32'h8000_0180,1,0,0});
        t.push_back('{0,0,0,0,0,1,0,0,0, 32'h8000_0184,1,0,0});
        t.push_back('{0,0,0,1,1,1,0,32'h0000_4000,32'h0000_5000,
                      32'h0000_4000,1,0,0});
        t.push_back('{0,1,0,1,1,1,0,32'h0000_7000,32'h0000_7100,
                      32'h0000_4000,1,1,0});
        t.push_back('{0,0,0,0,0,1,0,0,0, 32'h0000_7000,1,0,0});
        foreach (t[i]) begin
            apply(t[i]);
            @(posedge clk); #1;
            e   = sb.pop_front();
            got = {pc, pc_valid_o, redirect_pending_o, misalign_o,
                   pc_b, misalign_b};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL prio[%0d] got=%h exp=%h", i, got, e);
            end
        end
    endtask

    task automatic test_misalign();
        stim_t t[$];
        logic [68:0] e, got;
        t.push_back('{0,0,0,1,0,1,0,32'h0000_1002,0, 32'h0000_1002,1,0,1});
        t.push_back('{0,0,0,0,0,1,0,0,0, 32'h0000_1006,1,0,1});
        t.push_back('{0,0,0,0,1,1,0,0,32'h0000_2001, 32'h0000_2001,1,0,1});
        t.push_back('{0,0,1,0,0,0,32'h0000_2000,0,0, 32'h0000_2000,1,0,0});
        foreach (t[i]) begin
            apply(t[i]);
            @(posedge clk); #1;
            e   = sb.pop_front();
            got = {pc, pc_valid_o, redirect_pending_o, misalign_o,
                   pc_b, misalign_b};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL misalign[%0d] got=%h exp=%h", i, got, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t t[$];
        logic [68:0] e, got;
        t.push_back('{0,0,0,1,0,1,0,32'h0000_A000,0, 32'h0000_A000,1,0,0});
        t.push_back('{0,0,0,0,1,1,0,0,32'h0000_B000, 32'h0000_B000,1,0,0});
        t.push_back('{0,0,0,1,0,1,0,32'h0000_C000,0, 32'h0000_C000,1,0,0});
        t.push_back('{0,0,0,0,0,1,0,0,0, 32'h0000_C004,1,0,0});
        foreach (t[i]) begin
            apply(t[i]);
            @(posedge clk); #1;
            e   = sb.pop_front();
            got = {pc, pc_valid_o, redirect_pending_o, misalign_o,
                   pc_b, misalign_b};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL b2b[%0d] got=%h exp=%h", i, got, e);
            end
        end
    endtask

    task automatic test_reset_pending();
        stim_t t[$];
        logic [68:0] e, got;
        t.push_back('{0,1,0,0,1,1,0,0,32'h0000_9000, 32'h0000_C004,1,1,0});
        t.push_back('{1,1,1,1,1,1,32'h8000_0180,32'h0000_4000,32'h0000_5000,
                      32'hBFC0_0000,0,0,0});
        t.push_back('{0,0,0,0,0,1,0,0,0, 32'hBFC0_0000,1,0,0});
        t.push_back('{0,0,0,0,0,1,0,0,0, 32'hBFC0_0004,1,0,0});
        foreach (t[i]) begin
            apply(t[i]);
            @(posedge clk); #1;
            e   = sb.pop_front();
            got = {pc, pc_valid_o, redirect_pending_o, misalign_o,
                   pc_b, misalign_b};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL rstpend[%0d] got=%h exp=%h", i, got, e);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_wrap();
        test_held_redirect();
        test_priority();
        test_misalign();
        test_back_to_back();
        test_reset_pending();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard left=%0d exp=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
